super_large_number_sweeper: RTL

Sequential stimulus and response-collection stage wrapped around the SuperLargeNumber top entity.
- Upstream role: drives its signed 7-bit operand input.
- Downstream role: consumes its 1-bit result.
- On start, sweeps every signed WIDTH-bit value from most negative to most positive, tallies results equal to 1, captures the first operand that produced a 1, and flags completion.
- Replaces the fixed-time, undriven-input test harness with an exhaustive, self-terminating sweep usable in simulation and on hardware.

---
 rtl/super_large_number_pkg.sv | 14 +
 rtl/super_large_number_sweeper_tag_pipe.sv | 44 ++++
 rtl/super_large_number_sweeper.sv | 121 ++++++++++++
 3 files changed

// File: rtl/super_large_number_pkg.sv
// Shared types and constants for the SuperLargeNumber operand sweeper.
package super_large_number_pkg;

  localparam int WIDTH = 7;

  typedef logic signed [WIDTH-1:0] operand_t;
  typedef logic [WIDTH:0]          count_t;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} sweep_state_t;

  localparam operand_t OPERAND_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam operand_t OPERAND_MAX = {1'b0, {(WIDTH-1){1'b1}}};

endpackage

// File: rtl/super_large_number_sweeper_tag_pipe.sv
// LATENCY-deep {valid, value} delay line that pairs each issued operand with its
// returning result; LATENCY=0 is a straight pass-through of the current issue.
module sweep_tag_pipe #(
  parameter int WIDTH   = 7,
  parameter int LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic signed [WIDTH-1:0] i_value,
  output logic                    o_vld,
  output logic signed [WIDTH-1:0] o_value,
  output logic                    o_inflight
);

  localparam int DEPTH = (LATENCY > 0) ? LATENCY : 1;

  logic [DEPTH-1:0]        r_vld_p0;
  logic signed [WIDTH-1:0] r_value_p0 [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= '0;
    end else begin
      r_vld_p0[0] <= i_vld;
      for (int k = 1; k < DEPTH; k++) r_vld_p0[k] <= r_vld_p0[k-1];
    end
  end

  always_ff @(posedge clk) begin
    r_value_p0[0] <= i_value;
    for (int k = 1; k < DEPTH; k++) r_value_p0[k] <= r_value_p0[k-1];
  end

  assign o_vld   = (LATENCY == 0) ? i_vld   : r_vld_p0[DEPTH-1];
  assign o_value = (LATENCY == 0) ? i_value : r_value_p0[DEPTH-1];

  // Tags that will still be in flight after the next shift (the tap excluded).
  always_comb begin
    o_inflight = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) o_inflight = o_inflight | r_vld_p0[k];
  end

endmodule

// File: rtl/super_large_number_sweeper.sv
// Exhaustive signed-operand sweep around SuperLargeNumber: issues every operand
// once, counts results equal to 1, records the first hitting operand.
module super_large_number_sweeper #(
  parameter int WIDTH   = super_large_number_pkg::WIDTH,
  parameter int LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    hold_i,
  input  logic                    result_i,
  output logic signed [WIDTH-1:0] value_o,
  output logic                    value_vld_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [WIDTH:0]          hit_count_o,
  output logic signed [WIDTH-1:0] first_hit_o,
  output logic                    first_hit_vld_o
);

  import super_large_number_pkg::*;

  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]          CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  sweep_state_t            r_state;
  sweep_state_t            w_state_nxt;
  logic signed [WIDTH-1:0] r_value;
  logic [WIDTH:0]          r_hit_count;
  logic signed [WIDTH-1:0] r_first_hit;
  logic                    r_first_hit_vld;

  logic                    w_issue;
  logic                    w_last;
  logic                    w_start_ok;
  logic                    w_tap_vld;
  logic signed [WIDTH-1:0] w_tap_value;
  logic                    w_inflight;

  assign w_issue = (r_state == SWEEP) && !hold_i;
  assign w_last  = w_issue && (r_value == MAX_V);

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_state_nxt = SWEEP;
          w_start_ok  = 1'b1;
        end
      end
      SWEEP: begin
        if (w_last) w_state_nxt = (LATENCY > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (!w_inflight) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand counter: stops on the most positive value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (w_start_ok) begin
      r_value <= MIN_V;
    end else if (w_issue && !w_last) begin
      r_value <= r_value + ONE_V;
    end
  end

  sweep_tag_pipe #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (w_issue),
    .i_value   (r_value),
    .o_vld     (w_tap_vld),
    .o_value   (w_tap_value),
    .o_inflight(w_inflight)
  );

  // Collection stage: results only count against a valid tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count     <= '0;
      r_first_hit     <= '0;
      r_first_hit_vld <= 1'b0;
    end else if (w_start_ok) begin
      r_hit_count     <= '0;
      r_first_hit     <= '0;
      r_first_hit_vld <= 1'b0;
    end else if (w_tap_vld && result_i) begin
      r_hit_count <= r_hit_count + CNT_ONE;
      if (!r_first_hit_vld) begin
        r_first_hit     <= w_tap_value;
        r_first_hit_vld <= 1'b1;
      end
    end
  end

  assign value_o         = r_value;
  assign value_vld_o     = w_issue;
  assign busy_o          = (r_state == SWEEP) || (r_state == DRAIN);
  assign done_o          = (r_state == DONE);
  assign hit_count_o     = r_hit_count;
  assign first_hit_o     = r_first_hit;
  assign first_hit_vld_o = r_first_hit_vld;

endmodule
